light_phase_ctrl: RTL and testbench

LIGHT_PHASE_CTRL -- requirements
Module: light_phase_ctrl

---
 rtl/light_phase_ctrl.sv | 152 +++++++++++++++
 tb/tb_light_phase_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/light_phase_ctrl.sv
// Two-road traffic light phase controller: timed main/country phases with
// car-sensor truncation, pedestrian requests and a flashing-yellow mode.
module light_phase_ctrl #(
  parameter int G_MAIN  = 25,
  parameter int G_PEAK  = 40,
  parameter int G_CTRY  = 15,
  parameter int Y_TIME  = 3,
  parameter int T_TRUNC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       Cm,
  input  logic       Cc,
  input  logic       PQm,
  input  logic       PQc,
  input  logic       peak,
  input  logic       set,
  output logic [2:0] m_led,
  output logic [2:0] c_led,
  output logic [7:0] cnt,
  output logic [1:0] phase,
  output logic       walk_m,
  output logic       walk_c
);

  typedef enum logic [2:0] {
    M_GREEN  = 3'd0,
    M_YELLOW = 3'd1,
    C_GREEN  = 3'd2,
    C_YELLOW = 3'd3,
    FLASH    = 3'd4
  } state_t;

  localparam logic [7:0] GM = 8'(G_MAIN);
  localparam logic [7:0] GP = 8'(G_PEAK);
  localparam logic [7:0] GC = 8'(G_CTRY);
  localparam logic [7:0] YT = 8'(Y_TIME);
  localparam logic [7:0] TT = 8'(T_TRUNC);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_m_q, pend_m_d, pend_c_q, pend_c_d;
  logic       blink_q, blink_d;
  logic [2:0] m_led_q, c_led_q;
  logic [1:0] phase_q;
  logic       walk_m_q, walk_c_q;
  logic [7:0] gm_load;

  assign gm_load = peak ? GP : GM;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_m_d = pend_m_q;
    pend_c_d = pend_c_q;
    blink_d  = blink_q;
    if (!set) begin
      if (state_q != FLASH) begin
        state_d  = FLASH;
        cnt_d    = 8'd0;
        pend_m_d = 1'b0;
        pend_c_d = 1'b0;
        blink_d  = 1'b1;
      end else if (tick) begin
        blink_d = ~blink_q;
      end
    end else if (state_q == FLASH) begin
      // leaving flash: the coincident tick is not counted
      state_d  = M_GREEN;
      cnt_d    = gm_load;
      pend_m_d = PQm;
      pend_c_d = 1'b0;
    end else begin
      if (PQm && state_q != C_GREEN) pend_m_d = 1'b1;
      if (PQc && state_q != M_GREEN) pend_c_d = 1'b1;
      if (tick) begin
        case (state_q)
          M_GREEN:
            if (cnt_q == 8'd1) begin
              if (Cc || pend_m_q) begin
                state_d = M_YELLOW;
                cnt_d   = YT;
              end else begin
                cnt_d = gm_load;
              end
            end else if (((Cc && !Cm) || pend_m_q) && cnt_q > TT) cnt_d = TT;
            else cnt_d = cnt_q - 8'd1;
          M_YELLOW:
            if (cnt_q == 8'd1) begin
              state_d  = C_GREEN;
              cnt_d    = GC;
              pend_m_d = 1'b0;
            end else cnt_d = cnt_q - 8'd1;
          C_GREEN:
            if (cnt_q == 8'd1) begin
              state_d = C_YELLOW;
              cnt_d   = YT;
            end else if (!Cc && cnt_q > TT) cnt_d = TT;
            else cnt_d = cnt_q - 8'd1;
          C_YELLOW:
            if (cnt_q == 8'd1) begin
              state_d  = M_GREEN;
              cnt_d    = gm_load;
              pend_c_d = 1'b0;
            end else cnt_d = cnt_q - 8'd1;
          default: ;
        endcase
      end
    end
  end

  // outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= M_GREEN;
      cnt_q    <= GM;
      pend_m_q <= 1'b0;
      pend_c_q <= 1'b0;
      blink_q  <= 1'b0;
      m_led_q  <= 3'b001;
      c_led_q  <= 3'b100;
      phase_q  <= 2'b00;
      walk_m_q <= 1'b0;
      walk_c_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_m_q <= pend_m_d;
      pend_c_q <= pend_c_d;
      blink_q  <= blink_d;
      phase_q  <= (state_d == FLASH) ? 2'b01 : state_d[1:0];
      walk_m_q <= (state_d == C_GREEN);
      walk_c_q <= (state_d == M_GREEN);
      case (state_d)
        M_GREEN:  begin m_led_q <= 3'b001; c_led_q <= 3'b100; end
        M_YELLOW: begin m_led_q <= 3'b010; c_led_q <= 3'b100; end
        C_GREEN:  begin m_led_q <= 3'b100; c_led_q <= 3'b001; end
        C_YELLOW: begin m_led_q <= 3'b100; c_led_q <= 3'b010; end
        default:  begin m_led_q <= {1'b0, blink_d, 1'b0}; c_led_q <= {1'b0, blink_d, 1'b0}; end
      endcase
    end
  end

  assign m_led  = m_led_q;
  assign c_led  = c_led_q;
  assign cnt    = cnt_q;
  assign phase  = phase_q;
  assign walk_m = walk_m_q;
  assign walk_c = walk_c_q;

endmodule

// File: tb/tb_light_phase_ctrl.sv
// Bench for light_phase_ctrl: directed vector table, hand corner sequences and
// randomized traffic checked every cycle against a phase/timer reference model.
module tb_light_phase_ctrl;

  localparam int G_MAIN = 25, G_PEAK = 40, G_CTRY = 15, Y_TIME = 3, T_TRUNC = 5;

  logic clk, rst, tick, Cm, Cc, PQm, PQc, peak, set;
  logic [2:0] m_led, c_led;
  logic [7:0] cnt;
  logic [1:0] phase;
  logic walk_m, walk_c;

  light_phase_ctrl #(.G_MAIN(G_MAIN), .G_PEAK(G_PEAK), .G_CTRY(G_CTRY),
                     .Y_TIME(Y_TIME), .T_TRUNC(T_TRUNC)) dut (
    .clk(clk), .rst(rst), .tick(tick), .Cm(Cm), .Cc(Cc), .PQm(PQm), .PQc(PQc),
    .peak(peak), .set(set), .m_led(m_led), .c_led(c_led), .cnt(cnt),
    .phase(phase), .walk_m(walk_m), .walk_c(walk_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // reference model: phase index 0..3 around the ring, 4 = flashing
  int  r_ph, r_cnt;
  bit  r_pm, r_pc, r_blink;

  function automatic int dur(int ph);
    case (ph)
      0:       return peak ? G_PEAK : G_MAIN;
      2:       return G_CTRY;
      default: return Y_TIME;
    endcase
  endfunction

  task automatic model_reset();
    r_ph = 0; r_cnt = G_MAIN; r_pm = 0; r_pc = 0; r_blink = 0;
  endtask

  task automatic model_step();
    bit npm, npc, cut;
    int nxt;
    if (!set) begin
      if (r_ph != 4) begin r_ph = 4; r_cnt = 0; r_pm = 0; r_pc = 0; r_blink = 1; end
      else if (tick) r_blink = !r_blink;
      return;
    end
    if (r_ph == 4) begin r_ph = 0; r_cnt = dur(0); r_pm = PQm; r_pc = 0; return; end
    npm = r_pm | (PQm && r_ph != 2);
    npc = r_pc | (PQc && r_ph != 0);
    if (tick) begin
      if (r_cnt == 1) begin
        nxt = (r_ph == 0 && !Cc && !r_pm) ? 0 : (r_ph + 1) % 4;
        if (nxt == 2) npm = 0;
        if (nxt == 0 && r_ph == 3) npc = 0;
        r_ph = nxt; r_cnt = dur(nxt);
      end else begin
        cut = (r_ph == 0 && ((Cc && !Cm) || r_pm)) || (r_ph == 2 && !Cc);
        r_cnt = (cut && r_cnt > T_TRUNC) ? T_TRUNC : r_cnt - 1;
      end
    end
    r_pm = npm; r_pc = npc;
  endtask

  task automatic check_model(string nm);
    logic [2:0] em, ec;
    logic [1:0] eph;
    eph = (r_ph == 4) ? 2'd1 : 2'(r_ph);
    case (r_ph)
      0: begin em = 3'b001; ec = 3'b100; end
      1: begin em = 3'b010; ec = 3'b100; end
      2: begin em = 3'b100; ec = 3'b001; end
      3: begin em = 3'b100; ec = 3'b010; end
      default: begin em = {1'b0, r_blink, 1'b0}; ec = em; end
    endcase
    n_tests++;
    if (phase !== eph || cnt !== 8'(r_cnt) || m_led !== em || c_led !== ec ||
        walk_m !== (r_ph == 2) || walk_c !== (r_ph == 0)) begin
      n_fail++;
      $display("FAIL %s t=%0t got ph=%b cnt=%0d m=%b c=%b wm=%b wc=%b exp ph=%b cnt=%0d m=%b c=%b wm=%b wc=%b",
               nm, $time, phase, cnt, m_led, c_led, walk_m, walk_c,
               eph, r_cnt, em, ec, r_ph == 2, r_ph == 0);
    end
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(bit t);
    tick = t;
    @(posedge clk);
    if (rst) model_step();
    #1;
    check_model("model");
    tick = 0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) cyc(1);
  endtask

  typedef struct {
    int         n;
    bit         cm, cc, pk, pqm;
    logic [1:0] ph;
    logic [7:0] cn;
  } vec_t;
  vec_t tbl[$];

  initial begin
    rst = 1; tick = 0; Cm = 1; Cc = 0; PQm = 0; PQc = 0; peak = 0; set = 1;
    model_reset();
    #2 rst = 0;
    #1;
    check_model("reset_async");
    chk("reset_cnt", cnt, 8'd25);
    @(posedge clk); #3 rst = 1;

    //         n   cm cc pk pq  ph  cnt
    tbl.push_back('{24, 1, 0, 0, 0, 2'd0, 8'd1});
    tbl.push_back('{ 1, 1, 0, 0, 0, 2'd0, 8'd25});
    tbl.push_back('{ 5, 1, 0, 0, 0, 2'd0, 8'd20});
    tbl.push_back('{ 1, 0, 1, 0, 0, 2'd0, 8'd5});
    tbl.push_back('{ 4, 0, 1, 0, 0, 2'd0, 8'd1});
    tbl.push_back('{ 1, 0, 1, 0, 0, 2'd1, 8'd3});
    tbl.push_back('{ 3, 0, 1, 0, 0, 2'd2, 8'd15});
    tbl.push_back('{15, 0, 1, 0, 0, 2'd3, 8'd3});
    tbl.push_back('{ 3, 1, 1, 1, 0, 2'd0, 8'd40});
    tbl.push_back('{40, 1, 1, 1, 0, 2'd1, 8'd3});
    tbl.push_back('{ 3, 1, 1, 1, 0, 2'd2, 8'd15});
    tbl.push_back('{15, 1, 1, 1, 0, 2'd3, 8'd3});
    tbl.push_back('{ 3, 1, 1, 1, 0, 2'd0, 8'd40});
    tbl.push_back('{ 0, 1, 0, 0, 1, 2'd0, 8'd40});
    tbl.push_back('{ 1, 1, 0, 0, 0, 2'd0, 8'd5});
    tbl.push_back('{ 4, 1, 0, 0, 0, 2'd0, 8'd1});
    tbl.push_back('{ 1, 1, 0, 0, 0, 2'd1, 8'd3});
    tbl.push_back('{ 3, 1, 0, 0, 0, 2'd2, 8'd15});
    tbl.push_back('{ 1, 1, 0, 0, 0, 2'd2, 8'd5});
    tbl.push_back('{ 4, 1, 0, 0, 0, 2'd2, 8'd1});
    tbl.push_back('{ 1, 1, 0, 0, 0, 2'd3, 8'd3});
    tbl.push_back('{ 3, 1, 0, 0, 0, 2'd0, 8'd25});
    foreach (tbl[k]) begin
      Cm = tbl[k].cm; Cc = tbl[k].cc; peak = tbl[k].pk; PQm = tbl[k].pqm;
      if (tbl[k].n == 0) cyc(0); else ticks(tbl[k].n);
      PQm = 0;
      chk($sformatf("vec%0d_phase", k), {6'd0, phase}, {6'd0, tbl[k].ph});
      chk($sformatf("vec%0d_cnt", k), cnt, tbl[k].cn);
    end

    // flash entry mid country-green, blink per tick, exit to main green
    Cm = 0; Cc = 1;
    ticks(1); ticks(5); ticks(3); ticks(2);
    chk("pre_flash_cnt", cnt, 8'd13);
    set = 0; cyc(1);
    chk("flash_phase", {6'd0, phase}, 8'd1);
    chk("flash_cnt", cnt, 8'd0);
    chk("flash_led_on", {2'd0, m_led, c_led}, 8'b00010010);
    chk("flash_walk", {6'd0, walk_m, walk_c}, 8'd0);
    cyc(1);
    chk("flash_led_off", {2'd0, m_led, c_led}, 8'd0);
    cyc(0);
    chk("flash_hold", {2'd0, m_led, c_led}, 8'd0);
    cyc(1);
    chk("flash_led_on2", {5'd0, m_led}, 8'b010);
    set = 1; cyc(1);
    chk("flash_exit_phase", {6'd0, phase}, 8'd0);
    chk("flash_exit_cnt", cnt, 8'd25);

    // async reset between edges during country yellow
    ticks(1); ticks(5); ticks(3); ticks(15); ticks(1);
    chk("cy_phase", {6'd0, phase}, 8'd3);
    chk("cy_cnt", cnt, 8'd2);
    #2 rst = 0;
    #1;
    model_reset();
    check_model("async_reset");
    chk("async_leds", {2'd0, m_led, c_led}, 8'b00001100);
    chk("async_walk", {6'd0, walk_m, walk_c}, 8'b01);
    set = 0;
    @(posedge clk); #3 rst = 1;
    cyc(0);
    chk("rel_flash_phase", {6'd0, phase}, 8'd1);
    chk("rel_flash_cnt", cnt, 8'd0);
    set = 1; cyc(0);
    chk("rel_mg_cnt", cnt, 8'd25);

    for (int i = 0; i < 6000; i++) begin
      if (set ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 9) == 0)) set = ~set;
      if ($urandom_range(0, 9) == 0) Cm = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) Cc = $urandom_range(0, 1);
      if ($urandom_range(0, 49) == 0) peak = $urandom_range(0, 1);
      PQm = ($urandom_range(0, 29) == 0);
      PQc = ($urandom_range(0, 29) == 0);
      cyc($urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
